memory_arbiter: RTL and testbench

//  Shares the single-ported testbench/SoC memory (valid/instr/addr/wdata/wstrb -> rdata/ready) between the

---
 rtl/memory_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_memory_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Shares one single-ported memory between a core's instruction-fetch
//            (imem) and data (dmem) ports. Each port has a one-entry request
//            buffer. Grants are round-robin, and only one memory transaction is
//            in flight at a time. A watchdog force-completes transactions the
//            memory never acknowledges.
// Ports    : clk, rst                - clock (rising edge), async active-high reset
//            imem_valid/addr         - fetch request (1-cycle pulse)
//            imem_rdata/ready        - fetch completion (1-cycle pulse)
//            dmem_valid/addr/wdata/wstrb - load/store request (wstrb 0 = load)
//            dmem_rdata/ready        - load/store completion (1-cycle pulse)
//            memory_valid/instr/addr/wdata/wstrb - transaction to memory
//            memory_rdata/ready      - memory response
//            memory_error            - watchdog fired (1-cycle pulse)
// Params   : TIMEOUT - WAIT cycles without memory_ready before forced
//            completion; 0 disables the watchdog
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready,
    output logic        memory_error
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    localparam logic c_PORT_I = 1'b0;
    localparam logic c_PORT_D = 1'b1;

    // A zero TIMEOUT still needs a one-bit counter to keep widths legal.
    localparam int unsigned c_CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        (TIMEOUT == 0) ? '0 : c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic c_WDOG_EN = (TIMEOUT != 0);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_owner;
    logic               r_last_grant;
    logic [c_CNT_W-1:0] r_cnt;

    logic               r_i_full;
    logic [31:0]        r_i_addr;
    logic               r_d_full;
    logic [31:0]        r_d_addr;
    logic [31:0]        r_d_wdata;
    logic [3:0]         r_d_wstrb;

    logic               r_mem_instr;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_wstrb;

    logic               w_i_elig;
    logic               w_d_elig;
    logic               w_wait;
    logic               w_timeout;
    logic               w_done;
    logic               w_grant;
    logic               w_win_d;
    logic               w_take_i;
    logic               w_take_d;
    logic [31:0]        w_sel_addr;
    logic [31:0]        w_sel_wdata;
    logic [3:0]         w_sel_wstrb;
    logic [31:0]        w_resp_data;

    // A port is eligible with a buffered request or a request arriving now,
    // so an uncontended request skips the buffer entirely.
    assign w_i_elig  = r_i_full | imem_valid;
    assign w_d_elig  = r_d_full | dmem_valid;

    assign w_wait    = (r_state == c_ST_WAIT);
    assign w_timeout = c_WDOG_EN & w_wait & ~memory_ready & (r_cnt == c_CNT_LAST);
    assign w_done    = w_wait & (memory_ready | w_timeout);

    // Grant opportunities: idle, or the cycle the in-flight transaction ends.
    assign w_grant   = ((r_state == c_ST_IDLE) | w_done) & (w_i_elig | w_d_elig);

    // On a tie the port that did not win last time goes first.
    assign w_win_d   = w_d_elig & (~w_i_elig | (r_last_grant == c_PORT_I));
    assign w_take_i  = w_grant & ~w_win_d;
    assign w_take_d  = w_grant &  w_win_d;

    // The buffered request is older than anything on the inputs, so it wins.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_wstrb = '0;
        if (w_win_d) begin
            w_sel_addr  = r_d_full ? r_d_addr  : dmem_addr;
            w_sel_wdata = r_d_full ? r_d_wdata : dmem_wdata;
            w_sel_wstrb = r_d_full ? r_d_wstrb : dmem_wstrb;
        end else begin
            w_sel_addr  = r_i_full ? r_i_addr  : imem_addr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (w_grant) w_state_nxt = c_ST_ISSUE;
            c_ST_ISSUE: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  if (w_done)  w_state_nxt = w_grant ? c_ST_ISSUE : c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_owner      <= c_PORT_I;
            r_last_grant <= c_PORT_D;
            r_cnt        <= '0;
            r_mem_instr  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_owner      <= w_win_d;
                r_last_grant <= w_win_d;
                r_mem_instr  <= ~w_win_d;
                r_mem_addr   <= w_sel_addr;
                r_mem_wdata  <= w_sel_wdata;
                r_mem_wstrb  <= w_sel_wstrb;
            end
            if (r_state == c_ST_ISSUE) begin
                r_cnt <= '0;
            end else if (w_wait && !memory_ready && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Request buffers. A granted port's slot is emptied; a request arriving
    // while the slot is full is dropped (one outstanding request per port).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i_full  <= 1'b0;
            r_i_addr  <= '0;
            r_d_full  <= 1'b0;
            r_d_addr  <= '0;
            r_d_wdata <= '0;
            r_d_wstrb <= '0;
        end else begin
            if (w_take_i) begin
                r_i_full <= 1'b0;
            end else if (imem_valid && !r_i_full) begin
                r_i_full <= 1'b1;
                r_i_addr <= imem_addr;
            end
            if (w_take_d) begin
                r_d_full <= 1'b0;
            end else if (dmem_valid && !r_d_full) begin
                r_d_full  <= 1'b1;
                r_d_addr  <= dmem_addr;
                r_d_wdata <= dmem_wdata;
                r_d_wstrb <= dmem_wstrb;
            end
        end
    end

    // A watchdog completion returns zero data instead of the bus value.
    assign w_resp_data  = memory_ready ? memory_rdata : 32'h0;

    assign imem_ready   = w_done & (r_owner == c_PORT_I);
    assign dmem_ready   = w_done & (r_owner == c_PORT_D);
    assign imem_rdata   = imem_ready ? w_resp_data : 32'h0;
    assign dmem_rdata   = dmem_ready ? w_resp_data : 32'h0;

    assign memory_valid = (r_state == c_ST_ISSUE);
    assign memory_instr = r_mem_instr;
    assign memory_addr  = r_mem_addr;
    assign memory_wdata = r_mem_wdata;
    assign memory_wstrb = r_mem_wstrb;
    assign memory_error = w_timeout;

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Scoreboard bench for memory_arbiter. Directed requests push the
//            expected memory transactions and port responses into queues; a
//            monitor pops and compares them whenever the DUT presents them.
//            A small memory model answers with a programmable latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_addr = '0;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr = '0;
    logic [31:0] dmem_wdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        memory_valid;
    logic        memory_instr;
    logic [31:0] memory_addr;
    logic [31:0] memory_wdata;
    logic [3:0]  memory_wstrb;
    logic [31:0] memory_rdata = '0;
    logic        memory_ready = 1'b0;
    logic        memory_error;

    memory_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .memory_valid(memory_valid), .memory_instr(memory_instr),
        .memory_addr(memory_addr), .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb), .memory_rdata(memory_rdata),
        .memory_ready(memory_ready), .memory_error(memory_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    logic [68:0] mq[$];     // {instr, addr, wdata, wstrb}
    logic [33:0] rq[$];     // {port(1=dmem), error, rdata}
    logic [68:0] m_exp;
    logic [33:0] r_exp;
    int last_mv = 0;
    int last_ir = 0;
    int last_dr = 0;

    bit          mem_en  = 1'b1;
    int          mem_lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_a   = '0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'hC0DE_0000);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: answers memory_valid after mem_lat cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (mem_en) begin
            memory_ready = 1'b0;
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    memory_ready = 1'b1;
                    memory_rdata = mdata(mem_a);
                end
            end
            if (memory_valid) begin
                mem_cnt = mem_lat;
                mem_a   = memory_addr;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (memory_valid) begin
                last_mv = cyc;
                if (mq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL mem_unexpected: got addr %0h expected no transaction", memory_addr);
                end else begin
                    m_exp = mq.pop_front();
                    chk("mem_txn", {memory_instr, memory_addr, memory_wdata, memory_wstrb}, m_exp);
                end
            end
            if (imem_ready && dmem_ready) begin
                total++; bad++;
                $display("FAIL both_ready: got 1 expected 0");
            end
            if (memory_error && !imem_ready && !dmem_ready) begin
                total++; bad++;
                $display("FAIL lone_error: got 1 expected 0");
            end
            if (imem_ready) begin
                last_ir = cyc;
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL imem_unexpected: got ready expected none");
                end else begin
                    r_exp = rq.pop_front();
                    chk("imem_resp", {1'b0, memory_error, imem_rdata}, r_exp);
                end
            end
            if (dmem_ready) begin
                last_dr = cyc;
                if (rq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL dmem_unexpected: got ready expected none");
                end else begin
                    r_exp = rq.pop_front();
                    chk("dmem_resp", {1'b1, memory_error, dmem_rdata}, r_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input logic i, input logic [31:0] a, input logic [31:0] w, input logic [3:0] s);
        mq.push_back({i, a, w, s});
    endtask

    task automatic push_rsp(input logic p, input logic [31:0] d, input logic e);
        rq.push_back({p, e, d});
    endtask

    task automatic drain();
        int n = 0;
        while ((mq.size() != 0 || rq.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (mq.size() != 0 || rq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d/%0d pending expected 0", mq.size(), rq.size());
            mq.delete();
            rq.delete();
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    int req_cyc;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
             imem_ready, dmem_ready, imem_rdata, dmem_rdata, memory_error}, '0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single fetch, latency check
        mem_lat = 1;
        req_cyc = cyc;
        imem_valid = 1'b1; imem_addr = 32'h100;
        push_mem(1'b1, 32'h100, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0000_0013, 1'b0);
        tick();
        imem_valid = 1'b0;
        drain();
        chk("t1_issue_lat", last_mv - req_cyc, 1);
        chk("t1_ready_lat", last_ir - last_mv, 1);

        // 2: single byte store
        dmem_valid = 1'b1; dmem_addr = 32'h1000; dmem_wdata = 32'hA5; dmem_wstrb = 4'b0001;
        push_mem(1'b0, 32'h1000, 32'hA5, 4'b0001);
        push_rsp(1'b1, mdata(32'h1000), 1'b0);
        tick();
        dmem_valid = 1'b0;
        drain();
        chk("t2_ready_lat", last_dr - last_mv, 1);

        // 3: tie -> imem first; then imem alone; then tie -> dmem first
        imem_valid = 1'b1; imem_addr = 32'h200;
        dmem_valid = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        push_mem(1'b1, 32'h200, 32'h0, 4'h0);
        push_mem(1'b0, 32'h2000, 32'h0, 4'h0);
        push_rsp(1'b0, mdata(32'h200), 1'b0);
        push_rsp(1'b1, mdata(32'h2000), 1'b0);
        tick();
        imem_valid = 1'b0; dmem_valid = 1'b0;
        drain();
        imem_valid = 1'b1; imem_addr = 32'h300;
        push_mem(1'b1, 32'h300, 32'h0, 4'h0);
        push_rsp(1'b0, mdata(32'h300), 1'b0);
        tick();
        imem_valid = 1'b0;
        drain();
        imem_valid = 1'b1; imem_addr = 32'h400;
        dmem_valid = 1'b1; dmem_addr = 32'h4000; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
        push_mem(1'b0, 32'h4000, 32'hDEAD_BEEF, 4'hF);
        push_mem(1'b1, 32'h400, 32'h0, 4'h0);
        push_rsp(1'b1, mdata(32'h4000), 1'b0);
        push_rsp(1'b0, mdata(32'h400), 1'b0);
        tick();
        imem_valid = 1'b0; dmem_valid = 1'b0;
        drain();

        // 4: dmem buffered during imem WAIT; second dmem request dropped
        mem_lat = 4;
        imem_valid = 1'b1; imem_addr = 32'h500;
        push_mem(1'b1, 32'h500, 32'h0, 4'h0);
        push_mem(1'b0, 32'h5000, 32'h1234_5678, 4'b0011);
        push_rsp(1'b0, mdata(32'h500), 1'b0);
        push_rsp(1'b1, mdata(32'h5000), 1'b0);
        tick();
        imem_valid = 1'b0;
        tick();
        dmem_valid = 1'b1; dmem_addr = 32'h5000; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'b0011;
        tick();
        dmem_addr = 32'h6000; dmem_wdata = 32'hFFFF_FFFF; dmem_wstrb = 4'hF;
        tick();
        dmem_valid = 1'b0;
        drain();
        chk("t4_issue_after_ready", last_mv - last_ir, 1);

        // 5: watchdog fires 8 cycles after ISSUE; latency 8 just avoids it
        mem_en = 1'b0; mem_cnt = 0;
        imem_valid = 1'b1; imem_addr = 32'h700;
        push_mem(1'b1, 32'h700, 32'h0, 4'h0);
        push_rsp(1'b0, 32'h0, 1'b1);
        tick();
        imem_valid = 1'b0;
        drain();
        chk("t5_timeout_lat", last_ir - last_mv, 8);
        mem_en = 1'b1; mem_lat = 8;
        dmem_valid = 1'b1; dmem_addr = 32'h7000; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
        push_mem(1'b0, 32'h7000, 32'h0, 4'h0);
        push_rsp(1'b1, mdata(32'h7000), 1'b0);
        tick();
        dmem_valid = 1'b0;
        drain();
        chk("t5_edge_lat", last_dr - last_mv, 8);

        // 6: reset during WAIT; late memory_ready must be ignored
        mem_en = 1'b0; mem_cnt = 0;
        imem_valid = 1'b1; imem_addr = 32'h800;
        push_mem(1'b1, 32'h800, 32'h0, 4'h0);
        tick();
        imem_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_in_reset",
            {memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
             imem_ready, dmem_ready, memory_error}, '0);
        tick();
        rst = 1'b0;
        tick();
        memory_ready = 1'b1; memory_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("t6_late_ready",
            {imem_ready, dmem_ready, imem_rdata, dmem_rdata, memory_valid, memory_error}, '0);
        tick();
        memory_ready = 1'b0;
        repeat (2) tick();
        chk("t6_no_issue", mq.size(), 0);
        mem_en = 1'b1; mem_lat = 1;
        imem_valid = 1'b1; imem_addr = 32'h900;
        dmem_valid = 1'b1; dmem_addr = 32'h9000; dmem_wdata = 32'h55; dmem_wstrb = 4'b0100;
        push_mem(1'b1, 32'h900, 32'h0, 4'h0);
        push_mem(1'b0, 32'h9000, 32'h55, 4'b0100);
        push_rsp(1'b0, mdata(32'h900), 1'b0);
        push_rsp(1'b1, mdata(32'h9000), 1'b0);
        tick();
        imem_valid = 1'b0; dmem_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
